// File: rtl/contador_pkg.sv
// Shared constants for the parameterised up/down counter: mode encodings
// and the legal parameter ranges checked at elaboration.
package contador_pkg;

  localparam logic COUNT_UP   = 1'b1;
  localparam logic COUNT_DOWN = 1'b0;
  localparam logic MODE_WRAP  = 1'b0;
  localparam logic MODE_SAT   = 1'b1;

  localparam int unsigned WIDTH_MIN     = 2;
  localparam int unsigned WIDTH_MAX     = 32;
  localparam int unsigned MAX_COUNT_MIN = 1;
  localparam int unsigned PRESCALE_MIN  = 1;
  localparam int unsigned PRESCALE_MAX  = 256;

  // Largest value representable in a counter of the given width.
  function automatic longint unsigned max_count_limit(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles by PRESCALE, producing a combinational tick
// on the last enabled cycle of each group; clear restarts the group.
module tick_prescaler
  import contador_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("tick_prescaler: PRESCALE=%0d outside legal range", PRESCALE);
  end

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Tick is consumed in the same edge that the counter steps on.
  assign tick = enable && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (enable) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/contador_param.sv
// Prescaled up/down counter with wrap or saturate at 0/MAX_COUNT,
// synchronous clamped load, terminal-count pulse and sticky boundary flag.
module contador_param
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 32'(max_count_limit(WIDTH)),
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] contador,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("contador_param: WIDTH=%0d outside legal range", WIDTH);
  end
  if (MAX_COUNT < MAX_COUNT_MIN ||
      64'(MAX_COUNT) > max_count_limit(WIDTH)) begin : g_bad_max
    $error("contador_param: MAX_COUNT=%0d illegal for WIDTH=%0d", MAX_COUNT, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

  logic             tick;
  logic             at_bound;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  // A load also restarts the prescaler so the next step needs a full group.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (load),
    .tick   (tick)
  );

  assign at_bound = (up_down == COUNT_UP) ? (cnt_q == MAX_W) : (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clear_ovf) begin
      ovf_d = 1'b0;
    end
    if (load) begin
      cnt_d = (load_value > MAX_W) ? MAX_W : load_value;
    end else if (tick) begin
      if (!at_bound) begin
        cnt_d = (up_down == COUNT_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end else begin
        // Bound tick: flag wins over a coincident clear.
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (sat_mode == MODE_WRAP) begin
          cnt_d = (up_down == COUNT_UP) ? '0 : MAX_W;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign contador = cnt_q;
  assign tc       = tc_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_contador_param.sv
// Scoreboard bench: three counter configurations share one randomized
// stimulus stream and are compared every cycle against a reference model.
module tb_contador_param;

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    int pre;
  } mst_t;

  typedef struct {
    bit rst;
    bit en;
    bit ud;
    bit sat;
    bit ld;
    bit clr;
    int lv;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic       sat_mode = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic       clear_ovf = 1'b0;

  logic [7:0] a_cnt, b_cnt;
  logic [3:0] c_cnt;
  logic       a_tc, b_tc, c_tc, a_ovf, b_ovf, c_ovf;

  int vectors = 0;
  int miscompares = 0;
  bit stim_done = 1'b0;

  mst_t q_a[$], q_b[$], q_c[$];
  mst_t m_a, m_b, m_c;

  always #5 clk = ~clk;

  contador_param #(.WIDTH(8), .MAX_COUNT(9), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .sat_mode(sat_mode),
    .load(load), .load_value(load_value), .clear_ovf(clear_ovf),
    .contador(a_cnt), .tc(a_tc), .ovf(a_ovf));

  contador_param #(.WIDTH(8), .MAX_COUNT(9), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .sat_mode(sat_mode),
    .load(load), .load_value(load_value), .clear_ovf(clear_ovf),
    .contador(b_cnt), .tc(b_tc), .ovf(b_ovf));

  contador_param #(.WIDTH(4), .MAX_COUNT(15), .PRESCALE(1)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .sat_mode(sat_mode),
    .load(load), .load_value(load_value[3:0]), .clear_ovf(clear_ovf),
    .contador(c_cnt), .tc(c_tc), .ovf(c_ovf));

  // Next-state of an ideal counter, written directly from the behavioural rules.
  function automatic mst_t ref_step(input mst_t s, input stim_t i, input int maxc, input int ps);
    mst_t n;
    bit   tick;
    n = s;
    n.tc = 1'b0;
    if (!i.rst) begin
      n.cnt = 0; n.ovf = 1'b0; n.pre = 0;
      return n;
    end
    tick = i.en && (s.pre == ps - 1);
    if (i.clr) n.ovf = 1'b0;
    if (i.ld) begin
      n.cnt = (i.lv > maxc) ? maxc : i.lv;
      n.pre = 0;
      return n;
    end
    if (i.en) n.pre = tick ? 0 : s.pre + 1;
    if (tick) begin
      if (i.ud && s.cnt < maxc)       n.cnt = s.cnt + 1;
      else if (!i.ud && s.cnt > 0)    n.cnt = s.cnt - 1;
      else begin
        n.tc = 1'b1;
        n.ovf = 1'b1;
        if (!i.sat) n.cnt = i.ud ? 0 : maxc;
      end
    end
    return n;
  endfunction

  task automatic apply(input bit r, input bit en, input bit ud, input bit sat,
                       input bit ld, input int lv, input bit clr);
    stim_t s;
    @(negedge clk);
    rst = r; enable = en; up_down = ud; sat_mode = sat;
    load = ld; load_value = 8'(lv); clear_ovf = clr;
    s.rst = r; s.en = en; s.ud = ud; s.sat = sat; s.ld = ld; s.clr = clr;
    s.lv = lv & 255;
    m_a = ref_step(m_a, s, 9, 1);
    m_b = ref_step(m_b, s, 9, 4);
    s.lv = lv & 15;
    m_c = ref_step(m_c, s, 15, 1);
    q_a.push_back(m_a);
    q_b.push_back(m_b);
    q_c.push_back(m_c);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents a fresh output every cycle.
  initial begin
    mst_t ea, eb, ec;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() != 0 && q_b.size() != 0 && q_c.size() != 0) begin
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        ec = q_c.pop_front();
        vectors++;
        chk("a_contador", 32'(a_cnt), 32'(ea.cnt));
        chk("a_tc",       32'(a_tc),  32'(ea.tc));
        chk("a_ovf",      32'(a_ovf), 32'(ea.ovf));
        chk("b_contador", 32'(b_cnt), 32'(eb.cnt));
        chk("b_tc",       32'(b_tc),  32'(eb.tc));
        chk("b_ovf",      32'(b_ovf), 32'(eb.ovf));
        chk("c_contador", 32'(c_cnt), 32'(ec.cnt));
        chk("c_tc",       32'(c_tc),  32'(ec.tc));
        chk("c_ovf",      32'(c_ovf), 32'(ec.ovf));
      end
    end
  end

  initial begin
    m_a = '{0, 1'b0, 1'b0, 0};
    m_b = m_a;
    m_c = m_a;

    // Reset overriding load and clear_ovf.
    apply(0, 1, 1, 0, 1, 5, 1);
    apply(0, 0, 0, 0, 0, 0, 0);

    // Up-wrap through MAX_COUNT with every cycle enabled.
    repeat (12) apply(1, 1, 1, 0, 0, 0, 0);

    // Saturating down-count from 1, then clear_ovf with no tick.
    apply(1, 0, 0, 0, 1, 1, 0);
    repeat (4) apply(1, 1, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 1, 0, 0, 1);
    apply(1, 0, 0, 1, 0, 0, 0);

    // Clamped load coincident with a tick, then an in-range load.
    apply(1, 1, 1, 0, 0, 0, 0);
    apply(1, 1, 1, 0, 1, 200, 0);
    repeat (3) apply(1, 1, 1, 0, 0, 0, 0);
    apply(1, 1, 1, 0, 1, 5, 0);
    repeat (2) apply(1, 1, 1, 0, 0, 0, 0);

    // Enable toggling every cycle.
    for (int k = 0; k < 20; k++) apply(1, k[0], 1, 0, 0, 0, 0);

    // Reset mid-count with load and clear_ovf asserted, then resume.
    repeat (6) apply(1, 1, 1, 0, 0, 0, 0);
    apply(0, 1, 1, 0, 1, 7, 1);
    repeat (9) apply(1, 1, 1, 0, 0, 0, 0);

    // Down-wrap from 0, then a bound tick coincident with clear_ovf.
    apply(1, 0, 0, 0, 1, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 1, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      bit r, en, ud, sat, ld, clr;
      int lv;
      r   = ($urandom_range(0, 63) != 0);
      en  = ($urandom_range(0, 3) != 0);
      ud  = 1'($urandom_range(0, 1));
      sat = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 7) == 0);
      lv  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
      apply(r, en, ud, sat, ld, lv, clr);
    end

    apply(1, 0, 0, 0, 0, 0, 0);
    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    if (q_a.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_a.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/contador_param.md
CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 SHALL have parameter MAX_COUNT, default 2**WIDTH-1, terminal value (legal range 1..2**WIDTH-1).
REQ-003 SHALL have parameter PRESCALE, default 1, enabled clk cycles per count step (legal range 1..256).
REQ-004 SHALL have one clock, clk, input, 1 bit; all state updates on its rising edge.
REQ-005 SHALL have reset rst, input, 1 bit, synchronous, active-low.
REQ-006 SHALL have enable, input, 1 bit: advances the prescaler when high.
REQ-007 SHALL have up_down, input, 1 bit: 1 = count up, 0 = count down.
REQ-008 SHALL have sat_mode, input, 1 bit: 1 = saturate at the bounds, 0 = wrap.
REQ-009 SHALL have load, input, 1 bit: synchronous load strobe.
REQ-010 SHALL have load_value, input, WIDTH bits: value taken on load.
REQ-011 SHALL have clear_ovf, input, 1 bit: clears the sticky flag.
REQ-012 SHALL have contador, output, WIDTH bits, registered count.
REQ-013 SHALL have tc, output, 1 bit, registered one-cycle terminal-count pulse.
REQ-014 SHALL have ovf, output, 1 bit, registered sticky boundary flag.

Function
REQ-015 SHALL generate an internal tick when enable=1 and prescaler count = PRESCALE-1; prescaler then returns to 0, else increments while enable=1, holds while enable=0.
REQ-016 SHALL, with PRESCALE=1, tick on every cycle with enable=1.
REQ-017 SHALL change contador only on tick or load; otherwise hold.
REQ-018 SHALL, on tick with up_down=1 and contador<MAX_COUNT, increment by 1; with up_down=0 and contador>0, decrement by 1.
REQ-019 SHALL, on tick at a bound (up at MAX_COUNT, down at 0), set contador to 0 (up) or MAX_COUNT (down) when sat_mode=0, or hold when sat_mode=1.
REQ-020 SHALL pulse tc for exactly the clock cycle following every bound tick, in either mode; saturated holds re-pulse on every further bound tick.
REQ-021 SHALL set ovf on every bound tick; clear_ovf clears it next edge; simultaneous set and clear leaves ovf=1.
REQ-022 SHALL, on load=1, set contador to load_value, clamped to MAX_COUNT if greater, and reset the prescaler to 0; load overrides a coincident tick (no step, no tc, no ovf set).
REQ-023 SHALL sample up_down and sat_mode only on the tick edge; changes between ticks have no effect.
REQ-024 SHALL keep contador within 0..MAX_COUNT at all times.

Reset
REQ-025 SHALL, on rst=0 at a clk edge, set contador=0, tc=0, ovf=0, prescaler=0, overriding load, tick and clear_ovf.
REQ-026 SHALL, on reset mid-count, discard partial prescaler progress; first tick after release requires PRESCALE enabled cycles.

Structure
REQ-027 SHALL place the mode constants (COUNT_UP/COUNT_DOWN, MODE_WRAP/MODE_SAT) and the parameter legality limits in package contador_pkg.
REQ-028 SHALL implement the prescaler as sub-module tick_prescaler (params PRESCALE; ports clk, rst, enable, clear, tick).
REQ-029 SHALL flag illegal parameter values at elaboration.

Verification (WIDTH=8, MAX_COUNT=9 unless noted)
REQ-030 Reset then enable=1, up_down=1, sat_mode=0, PRESCALE=1 for 12 cycles -> contador 1..9,0,1,2; tc high only in the cycle after the 9->0 step; ovf=1 from then on.
REQ-031 PRESCALE=4, enable toggled every 10 ns with a 10 ns clk -> contador steps once per 4 enabled cycles; held while enable=0.
REQ-032 sat_mode=1, up_down=0 from 1 -> 1,0,0,0; tc pulses after each tick at 0; ovf=1; clear_ovf with no tick -> ovf=0 next cycle.
REQ-033 load=1, load_value=200 coincident with a tick -> contador=9, no tc, prescaler restarts; load_value=5 -> contador=5.
REQ-034 rst=0 asserted mid-count with load=1 and clear_ovf=1 -> contador=0, tc=0, ovf=0 next edge; count resumes after PRESCALE enabled cycles.
REQ-035 WIDTH=4, MAX_COUNT=15, down wrap from 0 -> contador=15 with tc pulse; ovf and clear_ovf coincident -> ovf stays 1.
